// File: rtl/operand_collector.sv
// operand_collector: serial-to-parallel staging of NB_INS operands into one
// flat bundle for the p_nor gate array. Slot k maps to in_buses[k].
// Optional build macro OPERAND_COLLECTOR_FLUSH_EN adds in_last for short
// bundles whose unused slots are zero-filled (zero is the OR identity).
module operand_collector #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned NB_INS    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BUS_WIDTH-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NB_INS*BUS_WIDTH-1:0]   out_bundle,
  output logic [$clog2(NB_INS+1)-1:0]   fill_count
`ifdef OPERAND_COLLECTOR_FLUSH_EN
  ,
  input  logic                          in_last
`endif
);

  localparam int unsigned CW = $clog2(NB_INS + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               fill_count_q, fill_count_d;
  logic [NB_INS*BUS_WIDTH-1:0] bundle_q, bundle_d;
  logic                        last_op;

`ifdef OPERAND_COLLECTOR_FLUSH_EN
  assign last_op = in_last;
`else
  assign last_op = 1'b0;
`endif

  // State, slot counter and bundle registers; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      fill_count_q <= '0;
      bundle_q     <= '0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      bundle_q     <= bundle_d;
    end
  end

  // Next-state: clear overrides both accept and output handshake.
  // In FILL in_ready is 1, so in_valid alone qualifies an accept.
  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    bundle_d     = bundle_q;
    if (clear) begin
      state_d      = FILL;
      fill_count_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < NB_INS; k++) begin
              if (CW'(k) == fill_count_q) begin
                bundle_d[k*BUS_WIDTH +: BUS_WIDTH] = in_data;
              end else if (last_op && (CW'(k) > fill_count_q)) begin
                bundle_d[k*BUS_WIDTH +: BUS_WIDTH] = '0;
              end
            end
            if ((fill_count_q == CW'(NB_INS - 1)) || last_op) begin
              state_d      = HOLD;
              fill_count_d = CW'(NB_INS);
            end else begin
              fill_count_d = fill_count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d      = FILL;
            fill_count_d = '0;
          end
        end
        default: begin
          state_d      = FILL;
          fill_count_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from registers only; no in_* or out_ready feedthrough.
  always_comb begin
    in_ready   = (state_q == FILL);
    out_valid  = (state_q == HOLD);
    out_bundle = bundle_q;
    fill_count = fill_count_q;
  end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Serial-to-parallel operand staging stage that sits directly upstream of the p_nor multi-input bitwise gate.
- Accepts operands one per handshake on a single BUS_WIDTH channel and packs NB_INS of them into one flat bundle.
- Presents the bundle with a valid/ready handshake so the gate array sees all NB_INS inputs stable at once.
- Bundle slot k maps to p_nor in_buses[k].

Parameters:
- BUS_WIDTH, 4, width of each operand.
- NB_INS, 3, operands per bundle; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: discards a partial or held bundle.
- in_valid  input  1  operand offered.
- in_ready  output  1  collector can accept an operand.
- in_data  input  BUS_WIDTH  operand value.
- out_valid  output  1  complete bundle held.
- out_ready  input  1  consumer takes the bundle.
- out_bundle  output  NB_INS*BUS_WIDTH  slot k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- fill_count  output  clog2(NB_INS+1)  number of slots currently written.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=FILL, fill_count=0, in_ready=1, out_valid=0, out_bundle=all zeros.
  - Reset asserted mid-bundle or mid-hold drops everything immediately, without waiting for a clock edge.
- States: FILL and HOLD.
- FILL:
  - in_ready=1 and out_valid=0.
  - An accept (in_valid&&in_ready at the edge) writes in_data to slot fill_count and increments fill_count.
  - An accept when fill_count==NB_INS-1 writes the last slot, sets fill_count=NB_INS and moves to HOLD. out_valid rises the cycle after that last accept, so latency from last operand to valid is 1 cycle.
- HOLD:
  - in_ready=0, out_valid=1, and out_bundle is stable.
  - in_valid is ignored; the upstream stalls.
  - out_valid&&out_ready at the edge moves to FILL with fill_count=0 and in_ready=1 on the next cycle.
  - out_bundle keeps its last value after the handoff; it is not zeroed.
- Throughput: NB_INS+1 cycles per bundle with continuous valid/ready.
- Slot order: the first accepted operand goes to slot 0. No reordering.
- Slots are not cleared between bundles. Every slot is overwritten before the next out_valid, so stale data is never presented as valid.
- clear:
  - Forces FILL and fill_count=0 on the edge, and out_valid falls the next cycle.
  - clear has priority over a simultaneous accept (the operand is dropped) and over a simultaneous out handshake (no double count).
  - clear while in FILL with fill_count==0 is a no-op.
- The output is a pure register. No combinational path from in_* to out_*, and none from out_ready to in_ready.
- Handshake rules:
  - out_valid never drops without a handshake, clear or reset.
  - out_bundle never changes while out_valid=1.
- fill_count never exceeds NB_INS.

Optional Feature:
- Macro: OPERAND_COLLECTOR_FLUSH_EN.
- Defined:
  - Adds port in_last (input, 1): marks the final operand of a short bundle.
  - An accept with in_last=1 at fill_count=j writes slot j and zero-fills slots j+1..NB_INS-1. Zero is the identity for the OR inside the NOR.
  - It then goes to HOLD with fill_count=NB_INS.
  - in_last on the slot NB_INS-1 accept behaves as a normal final accept.
- Not defined:
  - No in_last port exists.
  - Bundles complete only after exactly NB_INS accepts.

Test Plan:
- Reset then stream 4'b1001, 4'b1011, 4'b1011 with out_ready=0 -> out_valid rises 1 cycle after the 3rd accept and in_ready=0. out_bundle=12'b1011_1011_1001 held for 5 cycles. Downstream p_nor out_bus=4'b0100.
- Hold out_valid, pulse out_ready for 1 cycle -> next cycle out_valid=0, in_ready=1, fill_count=0. Then stream 4'h0, 4'h0, 4'h0 -> p_nor out_bus=4'b1111.
- Continuous in_valid and out_ready with 9 operands -> 3 bundles, each exactly 4 cycles apart, with slot contents in arrival order.
- Accept 2 operands, then assert clear together with in_valid -> fill_count=0 and the third operand is dropped. Three fresh operands then produce a bundle containing only the fresh values.
- Assert rst_n=0 asynchronously between edges while in HOLD -> out_valid=0 and out_bundle=0 immediately. After release, in_ready=1.
- With OPERAND_COLLECTOR_FLUSH_EN: accept 4'b0110 with in_last=1 at slot 0 -> out_bundle=12'b0000_0000_0110 and p_nor out_bus=4'b1001.
